cmac_tx_pkt_arbiter: RTL and testbench

Packet-granular 2:1 AXI-Stream arbiter that shares the single CMAC TX stream (512-bit, XDMA clock domain) between the XDMA H2C stream (source 0) and the UDP perf-generator stream (source 1). It grants whole packets in round-robin order and never interleaves beats of different packets. It truncates runaway packets at a beat limit and exposes per-source packet counters and a truncation counter to the perf ILA. Its output feeds the cross-die TX buffer ahead of the CMAC wrapper.

---
 rtl/axis_pkg.sv | 19 +
 rtl/axis_out_reg.sv | 57 +++++
 rtl/cmac_tx_pkt_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cmac_tx_pkt_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
`timescale 1ns/1ps
// Shared AXI-Stream widths and the packet arbiter state encoding for the CMAC-side blocks.
package axis_pkg;

    localparam int AXIS_TDATA_W = 512;
    localparam int AXIS_TKEEP_W = AXIS_TDATA_W / 8;
    localparam int AXIS_TUSER_W = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } arb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
`timescale 1ns/1ps
// Single-entry AXI-Stream output register; payload is frozen while valid is held against a stall.
module axis_out_reg #(
    parameter int DW = 512,
    parameter int KW = 64,
    parameter int UW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic [KW-1:0] i_keep,
    input  logic [UW-1:0] i_user,
    input  logic          i_last,
    output logic          o_load_ok,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [KW-1:0] o_keep,
    output logic [UW-1:0] o_user,
    output logic          o_last,
    input  logic          i_ready
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [KW-1:0] r_keep;
    logic [UW-1:0] r_user;
    logic          r_last;

    // Accept a new beat when empty or when the held beat leaves this cycle.
    assign o_load_ok = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_user  <= '0;
            r_last  <= 1'b0;
        end else if (i_valid && o_load_ok) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_user  <= i_user;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_user  = r_user;
    assign o_last  = r_last;

endmodule

// File: rtl/cmac_tx_pkt_arbiter.sv
`timescale 1ns/1ps
// Packet-granular round-robin 2:1 AXIS arbiter in front of the CMAC TX path,
// with runaway-packet truncation and per-source statistics.
module cmac_tx_pkt_arbiter
    import axis_pkg::*;
#(
    parameter int TDATA_WIDTH   = AXIS_TDATA_W,
    parameter int TKEEP_WIDTH   = AXIS_TKEEP_W,
    parameter int TUSER_WIDTH   = AXIS_TUSER_W,
    parameter int MAX_PKT_BEATS = 32
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [1:0]             src_en,

    input  logic                   s0_axis_tvalid,
    output logic                   s0_axis_tready,
    input  logic                   s0_axis_tlast,
    input  logic [TDATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0] s0_axis_tuser,

    input  logic                   s1_axis_tvalid,
    output logic                   s1_axis_tready,
    input  logic                   s1_axis_tlast,
    input  logic [TDATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0] s1_axis_tuser,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,

    output logic [31:0]            pkt_cnt0,
    output logic [31:0]            pkt_cnt1,
    output logic [15:0]            trunc_cnt,
    output logic [1:0]             cur_grant
);

    localparam int BCW = $clog2(MAX_PKT_BEATS) + 1;

    arb_state_e         r_state;
    logic [1:0]         r_grant;
    logic               r_rr_last;
    logic [BCW-1:0]     r_beat_cnt;
    logic [1:0][31:0]   r_pkt_cnt;
    logic [15:0]        r_trunc_cnt;

    logic [1:0]             w_elig;
    logic                   w_gidx;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [TDATA_WIDTH-1:0] w_sel_data;
    logic [TKEEP_WIDTH-1:0] w_sel_keep;
    logic [TUSER_WIDTH-1:0] w_sel_user;
    logic [TUSER_WIDTH-1:0] w_out_user;
    logic [1:0]             w_s_ready;
    logic                   w_out_ok;
    logic                   w_acc;
    logic                   w_at_limit;
    logic                   w_cut;
    logic                   w_load;

    assign w_elig = {s1_axis_tvalid & src_en[1], s0_axis_tvalid & src_en[0]};
    assign w_gidx = r_grant[1];

    assign w_sel_valid = w_gidx ? s1_axis_tvalid : s0_axis_tvalid;
    assign w_sel_last  = w_gidx ? s1_axis_tlast  : s0_axis_tlast;
    assign w_sel_data  = w_gidx ? s1_axis_tdata  : s0_axis_tdata;
    assign w_sel_keep  = w_gidx ? s1_axis_tkeep  : s0_axis_tkeep;
    assign w_sel_user  = w_gidx ? s1_axis_tuser  : s0_axis_tuser;

    // Only the granted source sees ready; DROP swallows beats regardless of the output side.
    always_comb begin
        w_s_ready = 2'b00;
        case (r_state)
            PASS:    w_s_ready = r_grant & {2{w_out_ok}};
            DROP:    w_s_ready = r_grant;
            default: w_s_ready = 2'b00;
        endcase
    end

    assign s0_axis_tready = w_s_ready[0];
    assign s1_axis_tready = w_s_ready[1];

    assign w_acc      = w_sel_valid & (|w_s_ready);
    assign w_at_limit = (r_beat_cnt == BCW'(MAX_PKT_BEATS - 1));
    assign w_cut      = w_at_limit & ~w_sel_last;
    assign w_load     = (r_state == PASS) & w_acc;

    // A cut packet is closed on the output with tuser[0] flagged as an error marker.
    always_comb begin
        w_out_user = w_sel_user;
        if (w_cut) w_out_user[0] = 1'b1;
    end

    axis_out_reg #(
        .DW (TDATA_WIDTH),
        .KW (TKEEP_WIDTH),
        .UW (TUSER_WIDTH)
    ) u_out_reg (
        .clk       (CLK),
        .rst_n     (RST_N),
        .i_valid   (w_load),
        .i_data    (w_sel_data),
        .i_keep    (w_sel_keep),
        .i_user    (w_out_user),
        .i_last    (w_sel_last | w_cut),
        .o_load_ok (w_out_ok),
        .o_valid   (m_axis_tvalid),
        .o_data    (m_axis_tdata),
        .o_keep    (m_axis_tkeep),
        .o_user    (m_axis_tuser),
        .o_last    (m_axis_tlast),
        .i_ready   (m_axis_tready)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_grant     <= 2'b00;
            r_rr_last   <= 1'b1;
            r_beat_cnt  <= '0;
            r_pkt_cnt   <= '0;
            r_trunc_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_elig) begin
                        r_state    <= PASS;
                        r_beat_cnt <= '0;
                        // Under contention the source not served last wins.
                        if (&w_elig) r_grant <= r_rr_last ? 2'b01 : 2'b10;
                        else         r_grant <= w_elig;
                    end
                end
                PASS: begin
                    if (w_acc) begin
                        r_beat_cnt <= r_beat_cnt + BCW'(1);
                        if (w_sel_last) begin
                            r_pkt_cnt[w_gidx] <= r_pkt_cnt[w_gidx] + 32'd1;
                            r_rr_last         <= w_gidx;
                            r_grant           <= 2'b00;
                            r_state           <= IDLE;
                        end else if (w_at_limit) begin
                            r_trunc_cnt <= sat_inc16(r_trunc_cnt);
                            r_rr_last   <= w_gidx;
                            r_state     <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (w_acc && w_sel_last) begin
                        r_grant <= 2'b00;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pkt_cnt0  = r_pkt_cnt[0];
    assign pkt_cnt1  = r_pkt_cnt[1];
    assign trunc_cnt = r_trunc_cnt;
    assign cur_grant = r_grant;

endmodule

// File: tb/tb_cmac_tx_pkt_arbiter.sv
`timescale 1ns/1ps
// Directed bench for cmac_tx_pkt_arbiter: expected output beats are queued as packets are
// issued and compared beat by beat (including while stalled) as the output presents them.
module tb_cmac_tx_pkt_arbiter;

    localparam int DW   = 512;
    localparam int KW   = 64;
    localparam int MAXB = 32;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          u;
        logic          l;
    } beat_t;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [1:0]        src_en;
    logic [1:0]        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [1:0][DW-1:0] s_tdata;
    logic [1:0][KW-1:0] s_tkeep;
    logic              m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [0:0]        m_tuser;
    logic [31:0]       pkt_cnt0, pkt_cnt1;
    logic [15:0]       trunc_cnt;
    logic [1:0]        cur_grant;

    beat_t sb[$];
    beat_t mon_e;
    int    total = 0;
    int    bad   = 0;
    int    exp_pkt[2];
    int    exp_trunc;
    int    exp_rr;
    bit    sb_on;
    bit    abort;
    bit    bp_mode;
    int    bp_cnt;

    always #5 CLK = ~CLK;

    cmac_tx_pkt_arbiter #(.MAX_PKT_BEATS(MAXB)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .src_en         (src_en),
        .s0_axis_tvalid (s_tvalid[0]),
        .s0_axis_tready (s_tready[0]),
        .s0_axis_tlast  (s_tlast[0]),
        .s0_axis_tdata  (s_tdata[0]),
        .s0_axis_tkeep  (s_tkeep[0]),
        .s0_axis_tuser  (s_tuser[0:0]),
        .s1_axis_tvalid (s_tvalid[1]),
        .s1_axis_tready (s_tready[1]),
        .s1_axis_tlast  (s_tlast[1]),
        .s1_axis_tdata  (s_tdata[1]),
        .s1_axis_tkeep  (s_tkeep[1]),
        .s1_axis_tuser  (s_tuser[1:1]),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tlast   (m_tlast),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tuser   (m_tuser),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1),
        .trunc_cnt      (trunc_cnt),
        .cur_grant      (cur_grant)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] df(input int src, input int pid, input int b);
        logic [DW-1:0] d;
        d = '0;
        d[7:0]     = 8'(src);
        d[23:8]    = 16'(pid);
        d[39:24]   = 16'(b);
        d[511:480] = 32'hC0DE0000 | 32'(pid * 64 + b);
        return d;
    endfunction

    function automatic logic [KW-1:0] kf(input bit last);
        return last ? 64'h0000_0000_0000_00FF : {KW{1'b1}};
    endfunction

    // Reference behaviour: beats past the limit vanish, the limit beat closes the packet with an error mark.
    task automatic push_pkt(input int src, input int pid, input int n);
        beat_t e;
        for (int b = 0; b < n && b < MAXB; b++) begin
            e.d = df(src, pid, b);
            e.k = kf(b == n - 1);
            e.l = (b == n - 1) || (b == MAXB - 1);
            e.u = (b == MAXB - 1) && (n > MAXB);
            sb.push_back(e);
        end
        if (n > MAXB) exp_trunc++;
        else          exp_pkt[src]++;
        exp_rr = src;
    endtask

    task automatic send_pkt(input int src, input int pid, input int n, output bit to);
        int w;
        to = 1'b0;
        for (int b = 0; b < n; b++) begin
            @(negedge CLK);
            s_tvalid[src] = 1'b1;
            s_tdata[src]  = df(src, pid, b);
            s_tkeep[src]  = kf(b == n - 1);
            s_tuser[src]  = 1'b0;
            s_tlast[src]  = (b == n - 1);
            w = 0;
            #4;
            while (!s_tready[src]) begin
                if (abort || w >= 300) begin
                    to = 1'b1;
                    s_tvalid[src] = 1'b0;
                    s_tlast[src]  = 1'b0;
                    return;
                end
                w++;
                @(negedge CLK);
                #4;
            end
            @(posedge CLK);
        end
    endtask

    task automatic idle_src(input int src);
        @(negedge CLK);
        s_tvalid[src] = 1'b0;
        s_tlast[src]  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 2000) begin
            @(negedge CLK);
            c++;
        end
        repeat (3) @(negedge CLK);
        chk(tag, 512'(sb.size()), 512'(0));
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_pkt0"},  512'(pkt_cnt0),  512'(exp_pkt[0]));
        chk({tag, "_pkt1"},  512'(pkt_cnt1),  512'(exp_pkt[1]));
        chk({tag, "_trunc"}, 512'(trunc_cnt), 512'(exp_trunc));
    endtask

    always @(negedge CLK) begin
        if (bp_mode) begin
            m_tready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
            bp_cnt++;
        end else begin
            m_tready = 1'b1;
        end
    end

    // Every presented beat must match the queue head, so a stalled beat is checked each cycle it is held.
    always @(negedge CLK) begin
        #4;
        if (RST_N && sb_on && m_tvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 512'(m_tvalid), 512'(0));
            end else begin
                mon_e = sb[0];
                chk("tdata", m_tdata, mon_e.d);
                chk("tkeep", 512'(m_tkeep), 512'(mon_e.k));
                chk("tuser", 512'(m_tuser), 512'(mon_e.u));
                chk("tlast", 512'(m_tlast), 512'(mon_e.l));
                if (m_tready) void'(sb.pop_front());
            end
        end
        if (RST_N) chk("one_ready", 512'(s_tready[0] & s_tready[1]), 512'(0));
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit to0, to1;
        int first;
        RST_N    = 1'b0;
        src_en   = 2'b00;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        m_tready = 1'b1;
        sb_on    = 1'b1;
        abort    = 1'b0;
        bp_mode  = 1'b0;
        bp_cnt   = 0;
        exp_pkt  = '{0, 0};
        exp_trunc = 0;
        exp_rr   = 1;

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_tvalid", 512'(m_tvalid), 512'(0));
        chk("rst_tlast",  512'(m_tlast),  512'(0));
        chk("rst_tdata",  m_tdata,        512'(0));
        chk("rst_tkeep",  512'(m_tkeep),  512'(0));
        chk("rst_tuser",  512'(m_tuser),  512'(0));
        chk("rst_tready", 512'(s_tready), 512'(0));
        chk("rst_grant",  512'(cur_grant), 512'(0));
        chk_cnts("rst");
        @(negedge CLK);
        RST_N = 1'b1;

        // Single source, three 4-beat packets
        src_en = 2'b01;
        for (int p = 0; p < 3; p++) push_pkt(0, p, 4);
        for (int p = 0; p < 3; p++) begin
            send_pkt(0, p, 4, to0);
            chk("single_to", 512'(to0), 512'(0));
        end
        idle_src(0);
        drain("single_drain");
        chk_cnts("single");

        // Contention, 2-beat packets, round robin
        src_en = 2'b11;
        first = (exp_rr == 1) ? 0 : 1;
        for (int i = 0; i < 6; i++) push_pkt(first ^ (i % 2), 10 + i / 2, 2);
        fork
            begin
                for (int p = 0; p < 3; p++) send_pkt(0, 10 + p, 2, to0);
                idle_src(0);
            end
            begin
                for (int p = 0; p < 3; p++) send_pkt(1, 10 + p, 2, to1);
                idle_src(1);
            end
        join
        drain("cont_drain");
        chk_cnts("cont");

        // Backpressure 1,0,0,1 with contention and 5-beat packets
        bp_cnt  = 0;
        bp_mode = 1'b1;
        first = (exp_rr == 1) ? 0 : 1;
        for (int i = 0; i < 4; i++) push_pkt(first ^ (i % 2), 20 + i / 2, 5);
        fork
            begin
                for (int p = 0; p < 2; p++) send_pkt(0, 20 + p, 5, to0);
                idle_src(0);
            end
            begin
                for (int p = 0; p < 2; p++) send_pkt(1, 20 + p, 5, to1);
                idle_src(1);
            end
        join
        drain("bp_drain");
        bp_mode = 1'b0;
        chk_cnts("bp");

        // Truncation of a 40-beat packet, then normal traffic
        push_pkt(1, 30, 40);
        send_pkt(1, 30, 40, to1);
        chk("trunc_to", 512'(to1), 512'(0));
        idle_src(1);
        drain("trunc_drain");
        chk_cnts("trunc");
        push_pkt(0, 31, 2);
        send_pkt(0, 31, 2, to0);
        idle_src(0);
        push_pkt(1, 32, 3);
        send_pkt(1, 32, 3, to1);
        idle_src(1);
        drain("post_trunc_drain");
        chk_cnts("post_trunc");

        // Enable cleared mid-packet: current packet completes, later source 0 packets are held off
        src_en = 2'b11;
        push_pkt(0, 40, 6);
        fork
            send_pkt(0, 40, 6, to0);
            begin
                repeat (4) @(negedge CLK);
                src_en = 2'b10;
            end
        join
        chk("en_cur_to", 512'(to0), 512'(0));
        idle_src(0);
        push_pkt(1, 41, 3);
        fork
            send_pkt(0, 42, 2, to0);
            begin
                send_pkt(1, 41, 3, to1);
                idle_src(1);
            end
        join
        chk("en_blocked", 512'(to0), 512'(1));
        chk("en_src1_to", 512'(to1), 512'(0));
        drain("en_drain");
        chk_cnts("en");

        // Reset during beat 3 of a packet
        src_en = 2'b11;
        sb_on  = 1'b0;
        fork
            send_pkt(0, 50, 6, to0);
            begin
                repeat (4) @(negedge CLK);
                #2;
                RST_N = 1'b0;
                abort = 1'b1;
                #1;
                chk("mid_rst_tvalid", 512'(m_tvalid),  512'(0));
                chk("mid_rst_pkt0",   512'(pkt_cnt0),  512'(0));
                chk("mid_rst_pkt1",   512'(pkt_cnt1),  512'(0));
                chk("mid_rst_trunc",  512'(trunc_cnt), 512'(0));
                chk("mid_rst_grant",  512'(cur_grant), 512'(0));
            end
        join
        chk("mid_rst_abort", 512'(to0), 512'(1));
        @(negedge CLK);
        RST_N = 1'b1;
        abort = 1'b0;
        sb.delete();
        exp_pkt   = '{0, 0};
        exp_trunc = 0;
        exp_rr    = 1;
        sb_on     = 1'b1;
        push_pkt(0, 60, 2);
        push_pkt(1, 60, 2);
        fork
            begin
                send_pkt(0, 60, 2, to0);
                idle_src(0);
            end
            begin
                send_pkt(1, 60, 2, to1);
                idle_src(1);
            end
        join
        drain("post_rst_drain");
        chk_cnts("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
